// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the EX stage: bus layouts, stall encoding,
// ALU op bit positions and the special-function decode codes.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_BUS_WD = 6;

  localparam int   STALL_ID = 2;
  localparam int   STALL_EX = 3;
  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_DIVU = 6'b011011;
  localparam logic [5:0] FUNC_MFHI = 6'b010000;
  localparam logic [5:0] FUNC_MFLO = 6'b010010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_to_mem_t;

  typedef struct packed {
    logic        fwd_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_to_id_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] x);
    return c ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider on operand magnitudes; signs are
// re-applied on the way out so HI/LO can be written straight from the ports.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        ack,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(DIV_CYCLES);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [31:0]   quo, rem, dvs;
  logic          neg_q, neg_r;
  logic [32:0]   trial;
  logic          fits;

  // Partial remainder with the next dividend bit shifted in; a zero divisor
  // always fits, which leaves q=all-ones and r=dividend with no special case.
  assign trial = {rem, quo[31]};
  assign fits  = trial >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          quo   <= neg_if(signed_op & a[31], a);
          dvs   <= neg_if(signed_op & b[31], b);
          rem   <= '0;
          neg_q <= signed_op & (a[31] ^ b[31]);
          neg_r <= signed_op & a[31];
          cnt   <= '0;
          state <= DIV_BUSY;
        end
        DIV_BUSY: begin
          quo <= {quo[30:0], fits};
          rem <= fits ? (trial[31:0] - dvs) : trial[31:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_if(neg_q, quo);
  assign remainder = neg_if(neg_r, rem);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand muxes, one-hot ALU, HI/LO with
// an iterative divider that holds the pipeline, and the data SRAM request.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);
  id_to_ex_t ex;

  // ID stalled while EX drains: insert a bubble rather than re-executing.
  always_ff @(posedge clk) begin
    if (rst)                                                  ex <= '0;
    else if (stall[STALL_ID] == STOP && stall[STALL_EX] == NO_STOP) ex <= '0;
    else if (stall[STALL_ID] == NO_STOP)                      ex <= id_to_ex_bus;
  end

  logic [31:0] imm_s, imm_z, sa, src1, src2, alu_res, ex_result;

  assign imm_s = {{16{ex.inst[15]}}, ex.inst[15:0]};
  assign imm_z = {16'd0, ex.inst[15:0]};
  assign sa    = {27'd0, ex.inst[10:6]};

  assign src1 = ({32{ex.src1[0]}} & ex.rdata1)
              | ({32{ex.src1[1]}} & ex.pc)
              | ({32{ex.src1[2]}} & sa);
  assign src2 = ({32{ex.src2[0]}} & ex.rdata2)
              | ({32{ex.src2[1]}} & imm_s)
              | ({32{ex.src2[2]}} & 32'd8)
              | ({32{ex.src2[3]}} & imm_z);

  always_comb begin
    alu_res = '0;
    if (ex.alu_op[ALU_ADD])  alu_res |= src1 + src2;
    if (ex.alu_op[ALU_SUB])  alu_res |= src1 - src2;
    if (ex.alu_op[ALU_SLT])  alu_res |= {31'd0, $signed(src1) < $signed(src2)};
    if (ex.alu_op[ALU_SLTU]) alu_res |= {31'd0, src1 < src2};
    if (ex.alu_op[ALU_AND])  alu_res |= src1 & src2;
    if (ex.alu_op[ALU_NOR])  alu_res |= ~(src1 | src2);
    if (ex.alu_op[ALU_OR])   alu_res |= src1 | src2;
    if (ex.alu_op[ALU_XOR])  alu_res |= src1 ^ src2;
    if (ex.alu_op[ALU_SLL])  alu_res |= src2 << src1[4:0];
    if (ex.alu_op[ALU_SRL])  alu_res |= src2 >> src1[4:0];
    if (ex.alu_op[ALU_SRA])  alu_res |= $unsigned($signed(src2) >>> src1[4:0]);
    if (ex.alu_op[ALU_LUI])  alu_res |= {src2[15:0], 16'd0};
  end

  logic special, is_div, is_divu, is_mfhi, is_mflo;
  assign special = (ex.inst[31:26] == 6'd0);
  assign is_div  = special & (ex.inst[5:0] == FUNC_DIV);
  assign is_divu = special & (ex.inst[5:0] == FUNC_DIVU);
  assign is_mfhi = special & (ex.inst[5:0] == FUNC_MFHI);
  assign is_mflo = special & (ex.inst[5:0] == FUNC_MFLO);

  logic        div_busy, div_done, retire;
  logic [31:0] div_q, div_r, hi, lo;

  assign retire = (stall[STALL_EX] == NO_STOP);

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div | is_divu),
    .signed_op (is_div),
    .ack       (retire),
    .a         (ex.rdata1),
    .b         (ex.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // HI/LO commit as the divide leaves EX, so a following MFHI/MFLO sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done && retire) begin
      hi <= div_r;
      lo <= div_q;
    end
  end

  assign stallreq_for_ex = ((is_div | is_divu) & ~div_busy & ~div_done) | div_busy;

  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  ex_to_mem_t mem;
  ex_to_id_t  fwd;
  assign mem = {ex.pc, ex.ram_en, ex.ram_wen, ex.sel_rf_res, ex.rf_we, ex.rf_waddr, ex_result};
  // Load data only exists after MEM, so loads never forward from here.
  assign fwd = {ex.rf_we & ~ex.sel_rf_res, ex.rf_waddr, ex_result};

  assign ex_to_mem_bus   = mem;
  assign ex_to_id_bus    = fwd;
  assign data_sram_en    = ex.ram_en;
  assign data_sram_wen   = ex.ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = ex.rdata2;

  logic unused;
  assign unused = ^{stall[5:4], stall[1:0], ex.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed and random instructions with random
// pipeline stalls, checked against a plain-arithmetic model of EX.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  wen;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        sel;
    logic [31:0] r1;
    logic [31:0] r2;
  } ins_t;

  typedef struct packed {
    logic [75:0] em;
    logic [37:0] ei;
    logic [68:0] es;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   ext_stall = '0;
  logic [5:0]   stall;
  logic         stallreq;
  logic [158:0] id_bus = '0;
  logic [75:0]  mem_bus;
  logic [37:0]  fwd_bus;
  logic         sram_en;
  logic [3:0]   sram_wen;
  logic [31:0]  sram_addr, sram_wdata;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [31:0] hi_m = '0, lo_m = '0;
  int   run = 0, last_run = 0;

  always #5 clk = ~clk;

  // Stand-in for the hazard unit: a divide freezes PC..EX.
  assign stall = stallreq ? 6'b001111 : ext_stall;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .stallreq_for_ex (stallreq),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (mem_bus),
    .ex_to_id_bus    (fwd_bus),
    .data_sram_en    (sram_en),
    .data_sram_wen   (sram_wen),
    .data_sram_addr  (sram_addr),
    .data_sram_wdata (sram_wdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic predict(input ins_t i);
    logic [31:0] a, b, res, q, r;
    longint n, d;
    bit sg;
    exp_t e;
    case (i.src1)
      3'b001:  a = i.r1;
      3'b010:  a = i.pc;
      3'b100:  a = {27'd0, i.inst[10:6]};
      default: a = 32'd0;
    endcase
    case (i.src2)
      4'b0001: b = i.r2;
      4'b0010: b = {{16{i.inst[15]}}, i.inst[15:0]};
      4'b0100: b = 32'd8;
      4'b1000: b = {16'd0, i.inst[15:0]};
      default: b = 32'd0;
    endcase
    case (i.alu_op)
      12'h800: res = a + b;
      12'h400: res = a - b;
      12'h200: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h100: res = (a < b) ? 32'd1 : 32'd0;
      12'h080: res = a & b;
      12'h040: res = ~(a | b);
      12'h020: res = a | b;
      12'h010: res = a ^ b;
      12'h008: res = b << a[4:0];
      12'h004: res = b >> a[4:0];
      12'h002: res = $unsigned($signed(b) >>> a[4:0]);
      12'h001: res = {b[15:0], 16'd0};
      default: res = 32'd0;
    endcase
    if (i.inst[31:26] == 6'd0) begin
      if (i.inst[5:0] == 6'h10) res = hi_m;
      else if (i.inst[5:0] == 6'h12) res = lo_m;
      else if (i.inst[5:0] == 6'h1a || i.inst[5:0] == 6'h1b) begin
        sg = (i.inst[5:0] == 6'h1a);
        if (sg) begin n = $signed(i.r1); d = $signed(i.r2); end
        else    begin n = i.r1;          d = i.r2;          end
        if (d == 0) begin
          q = (sg && i.r1[31]) ? 32'd1 : 32'hFFFF_FFFF;
          r = i.r1;
        end else begin
          q = 32'(n / d);
          r = 32'(n % d);
        end
        lo_m = q;
        hi_m = r;
      end
    end
    e.em = {i.pc, i.ram_en, i.wen, i.sel, i.rf_we, i.waddr, res};
    e.ei = {i.rf_we & ~i.sel, i.waddr, res};
    e.es = {i.ram_en, i.wen, res, i.r2};
    exp_q.push_back(e);
  endtask

  function automatic logic [5:0] pick_stall();
    int k = $urandom_range(0, 9);
    if (k < 6) return 6'b000000;
    if (k < 8) return 6'b000111;
    return 6'b001111;
  endfunction

  // Holds the instruction in ID until EX takes it.
  task automatic issue(input ins_t ins, input bit rnd);
    int tries = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge clk);
      id_bus    = ins;
      ext_stall = rnd ? pick_stall() : 6'b0;
      #4;
      if (stall[2] == 1'b0) begin
        acc = 1;
        if (ins.pc != 32'd0) predict(ins);
      end else if (++tries > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: pc %h never accepted", ins.pc);
        acc = 1;
      end
    end
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [11:0] op, input logic [2:0] s1,
                              input logic [3:0] s2, input logic ren,
                              input logic [3:0] wen, input logic we,
                              input logic [4:0] wa, input logic sel,
                              input logic [31:0] r1, input logic [31:0] r2);
    return '{pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
  endfunction

  function automatic ins_t rand_ins(input int n);
    ins_t i;
    int k;
    i.pc = 32'h0040_0000 + 32'(n) * 4;
    i.inst = $urandom;
    i.alu_op = '0;
    k = $urandom_range(0, 12);
    if (k < 12) i.alu_op[k] = 1'b1;
    i.src1 = '0;
    k = $urandom_range(0, 3);
    if (k < 3) i.src1[k] = 1'b1;
    i.src2 = '0;
    k = $urandom_range(0, 4);
    if (k < 4) i.src2[k] = 1'b1;
    i.ram_en = 1'($urandom);
    i.wen    = 4'($urandom);
    i.rf_we  = 1'($urandom);
    i.waddr  = 5'($urandom);
    i.sel    = 1'($urandom);
    i.r1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    i.r2     = $urandom;
    k = $urandom_range(0, 7);
    if (k == 0) begin
      i.inst[31:26] = 6'd0;
      i.inst[5:0]   = ($urandom_range(0, 1) == 0) ? 6'h1a : 6'h1b;
      case ($urandom_range(0, 3))
        0:       i.r2 = 32'd0;
        1:       i.r2 = 32'($urandom_range(1, 9));
        2:       i.r2 = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: i.r2 = $urandom;
      endcase
    end else if (k == 1) begin
      i.inst[31:26] = 6'd0;
      i.inst[5:0]   = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
    end else if (i.inst[31:26] == 6'd0 &&
                 (i.inst[5:0] == 6'h1a || i.inst[5:0] == 6'h1b ||
                  i.inst[5:0] == 6'h10 || i.inst[5:0] == 6'h12)) begin
      i.inst[5] = 1'b1;
    end
    return i;
  endfunction

  // Monitor: an instruction retires when it is in EX and EX is not frozen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && mem_bus[75:44] != 32'd0 && stall[3] == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: pc %h with empty scoreboard", mem_bus[75:44]);
        end else begin
          e = exp_q.pop_front();
          check("ex_to_mem", 128'(mem_bus), 128'(e.em));
          check("ex_to_id", 128'(fwd_bus), 128'(e.ei));
          check("sram", 128'({sram_en, sram_wen, sram_addr, sram_wdata}), 128'(e.es));
        end
      end
    end
  end

  // Length of the most recent stall-request burst.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) run = 0;
      else if (stallreq) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  localparam logic [31:0] DIV_M7_2  = {6'd0, 5'd1, 5'd2, 10'd0, 6'h1a};
  localparam logic [31:0] DIVU_INST = {6'd0, 5'd1, 5'd2, 10'd0, 6'h1b};
  localparam logic [31:0] MFLO_INST = {6'd0, 10'd0, 5'd8, 5'd0, 6'h12};
  localparam logic [31:0] MFHI_INST = {6'd0, 10'd0, 5'd9, 5'd0, 6'h10};

  initial begin
    ins_t nop = '0;
    // A divide sitting on the input during reset must not reach EX.
    id_bus = mk(32'h100, DIV_M7_2, 12'h800, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd3, 1'b0,
                32'hFFFF_FFF9, 32'd2);
    repeat (2) @(negedge clk);
    check("reset_mem", 128'(mem_bus), 128'd0);
    check("reset_id", 128'(fwd_bus), 128'd0);
    check("reset_sram", 128'({sram_en, sram_wen, sram_addr, sram_wdata}), 128'd0);
    check("reset_stallreq", 128'(stallreq), 128'd0);
    id_bus = '0;
    rst = 1'b0;

    issue(mk(32'h1000, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 12'h800, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd7, 32'd5), 0);
    issue(mk(32'h1004, {6'h0d, 5'd1, 5'd4, 16'h000F}, 12'h020, 3'b001, 4'b1000,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0000_00F0, 32'd0), 0);
    issue(mk(32'h1008, {6'h0f, 5'd0, 5'd5, 16'h1234}, 12'h001, 3'b000, 4'b1000,
             1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'd0, 32'd0), 0);
    issue(mk(32'hBFC0_0000, {6'h03, 26'd0}, 12'h800, 3'b010, 4'b0100,
             1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0), 0);
    issue(mk(32'h100C, {6'h2b, 5'd1, 5'd2, 16'h0008}, 12'h800, 3'b001, 4'b0010,
             1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF), 0);
    issue(mk(32'h1010, {6'h23, 5'd1, 5'd6, 16'hFFFC}, 12'h800, 3'b001, 4'b0010,
             1'b1, 4'h0, 1'b1, 5'd6, 1'b1, 32'h200, 32'h1234_5678), 0);
    issue(mk(32'h1014, {6'd0, 5'd0, 5'd2, 5'd7, 5'd4, 6'h03}, 12'h002, 3'b100, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'd0, 32'h8000_0010), 0);

    last_run = 0;
    issue(mk(32'h1018, DIV_M7_2, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'hFFFF_FFF9, 32'd2), 0);
    issue(mk(32'h101C, MFLO_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
             32'd0, 32'd0), 0);
    issue(mk(32'h1020, MFHI_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
             32'd0, 32'd0), 0);
    check("div_stall_cycles", 128'(last_run), 128'd33);

    issue(mk(32'h1024, DIVU_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'd100, 32'd0), 0);
    issue(mk(32'h1028, MFLO_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
             32'd0, 32'd0), 0);
    issue(mk(32'h102C, MFHI_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
             32'd0, 32'd0), 0);

    // Reset lands in the middle of a divide; the divide is abandoned.
    issue(mk(32'h1030, DIV_M7_2, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'd12345, 32'd7), 0);
    repeat (12) @(negedge clk);
    check("busy_before_reset", 128'(stallreq), 128'd1);
    rst = 1'b1;
    id_bus = '0;
    @(posedge clk);
    #1;
    check("midbusy_rst_stallreq", 128'(stallreq), 128'd0);
    check("midbusy_rst_mem", 128'(mem_bus), 128'd0);
    exp_q.delete();
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(mk(32'h1034, MFHI_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
             32'd0, 32'd0), 0);
    issue(mk(32'h1038, MFLO_INST, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
             32'd0, 32'd0), 0);

    for (int n = 0; n < 150; n++) issue(rand_ins(n), 1);

    issue(nop, 0);
    issue(nop, 0);
    @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
